data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL provide parameter MEM_WORDS, default 16384, meaning the number of 32-bit words stored (64 KB).
REQ-002 SHALL provide parameter LATENCY, default 4, legal range 1..20, meaning the number of cycles from load accept to load data return.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL provide port proc2mem_command, input, 2 bits: 0=BUS_NONE, 1=BUS_LOAD, 2=BUS_STORE; 3 is treated as BUS_NONE.
REQ-006 SHALL provide port proc2mem_addr, input, 32 bits: byte address.
REQ-007 SHALL provide port proc2mem_data, input, 32 bits: store data, right-aligned.
REQ-008 SHALL provide port proc2mem_size, input, 2 bits: 0=byte, 1=half, 2=word; 3 is treated as word.
REQ-009 SHALL provide port mem2proc_response, output, 4 bits: tag assigned to the request this cycle; 0 means rejected or idle. Combinational.
REQ-010 SHALL provide port mem2proc_error, output, 1 bit: high in the same cycle as a request rejected for misalignment or range. Combinational.
REQ-011 SHALL provide port mem2proc_tag, output, 4 bits: nonzero for exactly one cycle when load data returns. Registered.
REQ-012 SHALL provide port mem2proc_data, output, 32 bits: load return data, valid when mem2proc_tag != 0, otherwise 0. Registered.

Function
REQ-013 SHALL hold a next_tag counter over the range 1..15; on each accepted request it increments, wrapping 15 -> 1.
REQ-014 SHALL accept a LOAD or STORE only when all of these hold: the address is aligned (half: addr[0]=0; word: addr[1:0]=0); addr < MEM_WORDS*4; the busy bit of next_tag is clear.
REQ-015 SHALL, on accept, drive mem2proc_response=next_tag; on reject or BUS_NONE it SHALL drive 0.
REQ-016 SHALL NOT advance next_tag on a reject.
REQ-017 SHALL drive mem2proc_error=1 on a misaligned or out-of-range LOAD/STORE, and SHALL drive mem2proc_error=0 on a busy-tag reject.
REQ-018 SHALL, for an accepted store, write the array at the accept edge, updating only the byte lanes selected by size and addr[1:0]; data comes from the low bits of proc2mem_data.
REQ-019 SHALL NOT mark a store tag busy, and SHALL NOT return a completion for a store.
REQ-020 SHALL, for an accepted load, read the array at the accept edge (reflecting all earlier accepted stores), mark the tag busy, and enter {valid, tag, data} into a LATENCY-deep shift pipeline.
REQ-021 SHALL, for a load accepted in cycle T, drive mem2proc_tag=tag and mem2proc_data in cycle T+LATENCY; completions are in order, one per cycle maximum.
REQ-022 SHALL return byte and half loads zero-extended from the addressed lane into bits [7:0] or [15:0]; sign extension is the processor's job.
REQ-023 SHALL clear a tag's busy bit at the edge ending its completion cycle; the tag is reallocatable from the following cycle, not during the completion cycle itself.
REQ-024 SHALL treat a simultaneous accept and completion as independent; there is no bypass between them.
REQ-025 SHALL NOT give any response or completion for BUS_NONE.

Reset
REQ-026 SHALL, while rst=0, set mem2proc_tag=0, mem2proc_data=0, all pipeline valid bits=0, all busy bits=0, next_tag=1; mem2proc_response and mem2proc_error SHALL be 0.
REQ-027 SHALL NOT reset array contents; stores accepted before reset persist.
REQ-028 SHALL discard loads in flight at reset; no completion is ever issued for them.

Verification
REQ-029 SHALL be verified as follows: after reset release, store word 0xDEADBEEF @0x100, then load word @0x100 in the next cycle -> responses 1, 2; in cycle load+4, mem2proc_tag=2 and mem2proc_data=0xDEADBEEF.
REQ-030 SHALL be verified as follows: store word 0x11223344 @0x100, store byte 0xAB @0x101, load byte @0x101 -> data 0x000000AB; load word @0x100 -> data 0x1122AB44.
REQ-031 SHALL be verified as follows: load half @0x103 -> response 0, error 1, no completion, next accepted request gets the unchanged next_tag; load @MEM_WORDS*4 -> response 0, error 1.
REQ-032 SHALL be verified as follows: four back-to-back loads from cycle T -> responses 1..4; completions with tags 1..4 in cycles T+4..T+7 with correct data.
REQ-033 SHALL be verified as follows: with LATENCY=16, sixteen consecutive loads from cycle T -> tags 1..15 accepted; the 16th in T+15 gets response 0 with error 0; tag 1 returns in T+16; a retry in T+16 is rejected; a retry in T+17 gets response 1.
REQ-034 SHALL be verified as follows: three loads in flight, then rst=0 asserted asynchronously mid-cycle -> outputs go to 0 immediately; after release, no completion pulses appear, the first accepted request gets tag 1, and earlier stored data is still readable.

Source files
------------

// File: rtl/data_mem_responder.sv
// Tagged data-memory responder: stores complete at accept, and loads return in order after a
// fixed LATENCY through a shift pipeline. Each load tag stays busy until its completion has been
// issued.
module data_mem_responder #(
  parameter int unsigned MEM_WORDS = 16384,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [31:0] proc2mem_data,
  input  logic [1:0]  proc2mem_size,
  output logic [3:0]  mem2proc_response,
  output logic        mem2proc_error,
  output logic [3:0]  mem2proc_tag,
  output logic [31:0] mem2proc_data
);

  localparam int unsigned     AddrW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam longint unsigned MemBytes = 64'(MEM_WORDS) * 64'd4;
  localparam logic [1:0]      BusLoad  = 2'd1;
  localparam logic [1:0]      BusStore = 2'd2;
  localparam logic [1:0]      SzByte   = 2'd0;
  localparam logic [1:0]      SzHalf   = 2'd1;

  logic [31:0]      mem_q [MEM_WORDS];
  logic             pipe_valid_q [LATENCY];
  logic [3:0]       pipe_tag_q   [LATENCY];
  logic [31:0]      pipe_data_q  [LATENCY];
  logic [15:0]      busy_q, busy_d;
  logic [3:0]       next_tag_q, next_tag_d;

  logic             is_load, is_store, req_valid;
  logic             misaligned, in_range, accept, load_accept;
  logic [AddrW-1:0] word_idx;
  logic [1:0]       lane;
  logic [3:0]       byte_en;
  logic [31:0]      wr_data, rd_word, rd_shift, rd_data;

  // Requests are ignored entirely while reset is asserted.
  assign is_load   = rst && (proc2mem_command == BusLoad);
  assign is_store  = rst && (proc2mem_command == BusStore);
  assign req_valid = is_load || is_store;
  assign word_idx  = proc2mem_addr[AddrW+1:2];
  assign lane      = proc2mem_addr[1:0];
  assign in_range  = {32'd0, proc2mem_addr} < MemBytes;

  always_comb begin
    misaligned = 1'b0;
    byte_en    = 4'b1111;
    wr_data    = proc2mem_data;
    case (proc2mem_size)
      SzByte: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{proc2mem_data[7:0]}};
      end
      SzHalf: begin
        misaligned = proc2mem_addr[0];
        byte_en    = 4'b0011 << lane;
        wr_data    = {2{proc2mem_data[15:0]}};
      end
      default: misaligned = (lane != 2'b00);
    endcase
  end

  assign accept            = req_valid && !misaligned && in_range && !busy_q[next_tag_q];
  assign load_accept       = accept && is_load;
  assign mem2proc_response = accept ? next_tag_q : 4'd0;
  assign mem2proc_error    = req_valid && (misaligned || !in_range);

  // Zero-extend the addressed lane; the word case needs no shift since it is aligned.
  always_comb begin
    rd_word  = mem_q[word_idx];
    rd_shift = rd_word >> {lane, 3'b000};
    case (proc2mem_size)
      SzByte:  rd_data = {24'd0, rd_shift[7:0]};
      SzHalf:  rd_data = {16'd0, rd_shift[15:0]};
      default: rd_data = rd_word;
    endcase
  end

  always_comb begin
    next_tag_d = next_tag_q;
    if (accept) begin
      next_tag_d = (next_tag_q == 4'd15) ? 4'd1 : next_tag_q + 4'd1;
    end
  end

  // Completing and newly allocated tags never coincide: allocation requires a clear busy bit.
  always_comb begin
    busy_d = busy_q;
    if (pipe_valid_q[LATENCY-1]) begin
      busy_d[pipe_tag_q[LATENCY-1]] = 1'b0;
    end
    if (load_accept) begin
      busy_d[next_tag_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      next_tag_q <= 4'd1;
    end else begin
      busy_q     <= busy_d;
      next_tag_q <= next_tag_d;
    end
  end

  // Invalid stages carry zero tag and data, so the last stage drives the outputs directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_tag_q[i]   <= 4'd0;
        pipe_data_q[i]  <= 32'd0;
      end
    end else begin
      pipe_valid_q[0] <= load_accept;
      pipe_tag_q[0]   <= load_accept ? next_tag_q : 4'd0;
      pipe_data_q[0]  <= load_accept ? rd_data : 32'd0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_tag_q[i]   <= pipe_tag_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
    end
  end

  assign mem2proc_tag  = pipe_tag_q[LATENCY-1];
  assign mem2proc_data = pipe_data_q[LATENCY-1];

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept && is_store) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem_q[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: dut_a uses default parameters, dut_b uses LATENCY=16
// to exercise tag exhaustion and reallocation timing.
module tb_data_mem_responder;

  localparam logic [1:0] Ld = 2'd1, St = 2'd2, SzB = 2'd0, SzH = 2'd1, SzW = 2'd2;

  logic        clk, rst;
  logic [1:0]  cmd_a, size_a, cmd_b, size_b;
  logic [31:0] addr_a, data_a, addr_b, data_b;
  logic [3:0]  resp_a, tag_a, resp_b, tag_b;
  logic        err_a, err_b;
  logic [31:0] rdata_a, rdata_b;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder dut_a (
    .clk               (clk),
    .rst               (rst),
    .proc2mem_command  (cmd_a),
    .proc2mem_addr     (addr_a),
    .proc2mem_data     (data_a),
    .proc2mem_size     (size_a),
    .mem2proc_response (resp_a),
    .mem2proc_error    (err_a),
    .mem2proc_tag      (tag_a),
    .mem2proc_data     (rdata_a)
  );

  data_mem_responder #(.MEM_WORDS(1024), .LATENCY(16)) dut_b (
    .clk               (clk),
    .rst               (rst),
    .proc2mem_command  (cmd_b),
    .proc2mem_addr     (addr_b),
    .proc2mem_data     (data_b),
    .proc2mem_size     (size_b),
    .mem2proc_response (resp_b),
    .mem2proc_error    (err_b),
    .mem2proc_tag      (tag_b),
    .mem2proc_data     (rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic drive(input bit b, input logic [1:0] c, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s);
    if (b) begin
      cmd_b = c; addr_b = a; data_b = d; size_b = s;
    end else begin
      cmd_a = c; addr_a = a; data_a = d; size_a = s;
    end
  endtask

  // One request cycle: drive after the edge, check the combinational reply mid-cycle.
  task automatic req(input bit b, input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] s, input logic [3:0] er, input logic ee, input string nm);
    @(posedge clk);
    #1 drive(b, c, a, d, s);
    #4;
    if (b) begin
      check({nm, " resp"}, {28'd0, resp_b}, {28'd0, er});
      check({nm, " err"}, {31'd0, err_b}, {31'd0, ee});
    end else begin
      check({nm, " resp"}, {28'd0, resp_a}, {28'd0, er});
      check({nm, " err"}, {31'd0, err_a}, {31'd0, ee});
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1 drive(1'b0, 2'd0, 32'd0, 32'd0, SzW);
    drive(1'b1, 2'd0, 32'd0, 32'd0, SzW);
    #4;
  endtask

  task automatic out(input bit b, input logic [3:0] et, input logic [31:0] ed, input bit chk_data,
                     input string nm);
    if (b) begin
      check({nm, " tag"}, {28'd0, tag_b}, {28'd0, et});
      if (chk_data) check({nm, " data"}, rdata_b, ed);
    end else begin
      check({nm, " tag"}, {28'd0, tag_a}, {28'd0, et});
      if (chk_data) check({nm, " data"}, rdata_a, ed);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, Ld, 32'h100, 32'd0, SzW);
    drive(1'b1, Ld, 32'h0, 32'd0, SzW);
    #12;
    check("reset resp", {28'd0, resp_a}, 32'd0);
    check("reset err", {31'd0, err_a}, 32'd0);
    out(1'b0, 4'd0, 32'd0, 1'b1, "reset out");
    drive(1'b0, 2'd0, 32'd0, 32'd0, SzW);
    drive(1'b1, 2'd0, 32'd0, 32'd0, SzW);
    rst = 1'b1;

    // Store then load word
    req(1'b0, St, 32'h100, 32'hDEADBEEF, SzW, 4'd1, 1'b0, "st word");
    req(1'b0, Ld, 32'h100, 32'd0, SzW, 4'd2, 1'b0, "ld word");
    idle(); idle(); idle();
    out(1'b0, 4'd0, 32'd0, 1'b1, "no early cpl");
    idle();
    out(1'b0, 4'd2, 32'hDEADBEEF, 1'b1, "cpl deadbeef");

    // Byte-lane merge
    req(1'b0, St, 32'h100, 32'h11223344, SzW, 4'd3, 1'b0, "st word2");
    req(1'b0, St, 32'h101, 32'h123456AB, SzB, 4'd4, 1'b0, "st byte");
    req(1'b0, Ld, 32'h101, 32'd0, SzB, 4'd5, 1'b0, "ld byte");
    req(1'b0, Ld, 32'h100, 32'd0, SzW, 4'd6, 1'b0, "ld merged");
    idle(); idle(); idle();
    out(1'b0, 4'd5, 32'h000000AB, 1'b1, "cpl byte");
    idle();
    out(1'b0, 4'd6, 32'h1122AB44, 1'b1, "cpl merged");

    // Half-word lane and size 3 as word
    req(1'b0, St, 32'h102, 32'h9999CAFE, SzH, 4'd7, 1'b0, "st half");
    req(1'b0, Ld, 32'h102, 32'd0, SzH, 4'd8, 1'b0, "ld half");
    req(1'b0, Ld, 32'h100, 32'd0, 2'd3, 4'd9, 1'b0, "ld size3");
    idle(); idle(); idle();
    out(1'b0, 4'd8, 32'h0000CAFE, 1'b1, "cpl half");
    idle();
    out(1'b0, 4'd9, 32'hCAFEAB44, 1'b1, "cpl size3");

    // Rejections keep next_tag
    req(1'b0, Ld, 32'h103, 32'd0, SzH, 4'd0, 1'b1, "ld half misal");
    idle(); idle(); idle(); idle();
    out(1'b0, 4'd0, 32'd0, 1'b1, "no cpl reject");
    req(1'b0, Ld, 32'h10000, 32'd0, SzW, 4'd0, 1'b1, "ld range");
    req(1'b0, St, 32'h10000, 32'h1, SzW, 4'd0, 1'b1, "st range");
    req(1'b0, Ld, 32'h102, 32'd0, SzW, 4'd0, 1'b1, "ld word misal");
    req(1'b0, Ld, 32'h102, 32'd0, 2'd3, 4'd0, 1'b1, "ld size3 misal");
    req(1'b0, 2'd3, 32'h100, 32'd0, SzW, 4'd0, 1'b0, "cmd3 none");
    req(1'b0, St, 32'hFFFC, 32'h5A5A5A5A, SzW, 4'd10, 1'b0, "st top");

    // Loads in flight across an asynchronous reset
    req(1'b0, Ld, 32'h100, 32'd0, SzW, 4'd11, 1'b0, "ld fl1");
    req(1'b0, Ld, 32'hFFFC, 32'd0, SzW, 4'd12, 1'b0, "ld fl2");
    req(1'b0, Ld, 32'h101, 32'd0, SzB, 4'd13, 1'b0, "ld fl3");
    idle();
    @(posedge clk);
    #1 drive(1'b0, Ld, 32'h104, 32'd0, SzW);
    #1;
    out(1'b0, 4'd11, 32'hCAFEAB44, 1'b1, "pre-rst cpl");
    check("pre-rst resp", {28'd0, resp_a}, 32'd14);
    #1 rst = 1'b0;
    #1;
    out(1'b0, 4'd0, 32'd0, 1'b1, "async rst out");
    check("async rst resp", {28'd0, resp_a}, 32'd0);
    check("async rst err", {31'd0, err_a}, 32'd0);
    drive(1'b0, 2'd0, 32'd0, 32'd0, SzW);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      idle();
      out(1'b0, 4'd0, 32'd0, 1'b1, "no cpl post-rst");
    end

    // Back-to-back loads; data persisted through reset
    req(1'b0, Ld, 32'h100, 32'd0, SzW, 4'd1, 1'b0, "b2b ld1");
    req(1'b0, Ld, 32'hFFFC, 32'd0, SzW, 4'd2, 1'b0, "b2b ld2");
    req(1'b0, Ld, 32'h101, 32'd0, SzB, 4'd3, 1'b0, "b2b ld3");
    req(1'b0, Ld, 32'h102, 32'd0, SzH, 4'd4, 1'b0, "b2b ld4");
    idle();
    out(1'b0, 4'd1, 32'hCAFEAB44, 1'b1, "b2b cpl1");
    idle();
    out(1'b0, 4'd2, 32'h5A5A5A5A, 1'b1, "b2b cpl2");
    idle();
    out(1'b0, 4'd3, 32'h000000AB, 1'b1, "b2b cpl3");
    idle();
    out(1'b0, 4'd4, 32'h0000CAFE, 1'b1, "b2b cpl4");
    idle();
    out(1'b0, 4'd0, 32'd0, 1'b1, "b2b done");

    // Tag exhaustion with LATENCY=16
    for (int i = 0; i < 15; i++) begin
      req(1'b1, Ld, 32'(4 * i), 32'd0, SzW, 4'(i + 1), 1'b0, "lat16 ld");
    end
    req(1'b1, Ld, 32'h3C, 32'd0, SzW, 4'd0, 1'b0, "lat16 busy");
    out(1'b1, 4'd0, 32'd0, 1'b0, "lat16 no cpl yet");
    req(1'b1, Ld, 32'h40, 32'd0, SzW, 4'd0, 1'b0, "lat16 retry early");
    out(1'b1, 4'd1, 32'd0, 1'b0, "lat16 cpl1");
    req(1'b1, Ld, 32'h40, 32'd0, SzW, 4'd1, 1'b0, "lat16 retry ok");
    out(1'b1, 4'd2, 32'd0, 1'b0, "lat16 cpl2");
    idle();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
